// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, widths, slot states and the
// legality check used when capturing ALU results.
package alu_pkg;

   localparam int DATA_W = 32;
   localparam int OP_W   = 6;

   localparam logic [OP_W-1:0] ADD_OP  = 6'h00;
   localparam logic [OP_W-1:0] SUB_OP  = 6'h01;
   localparam logic [OP_W-1:0] SHL_OP  = 6'h02;
   localparam logic [OP_W-1:0] LSR_OP  = 6'h03;
   localparam logic [OP_W-1:0] ASR_OP  = 6'h04;
   localparam logic [OP_W-1:0] OR_OP   = 6'h05;
   localparam logic [OP_W-1:0] AND_OP  = 6'h06;
   localparam logic [OP_W-1:0] NOR_OP  = 6'h07;
   localparam logic [OP_W-1:0] XOR_OP  = 6'h08;
   localparam logic [OP_W-1:0] SLT_OP  = 6'h09;
   localparam logic [OP_W-1:0] SLTU_OP = 6'h0A;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

   function automatic logic is_legal_alu_op(input logic [OP_W-1:0] op);
      logic legal;
      case (op)
         ADD_OP, SUB_OP, SHL_OP, LSR_OP, ASR_OP, OR_OP,
         AND_OP, NOR_OP, XOR_OP, SLT_OP, SLTU_OP: legal = 1'b1;
         default:                                 legal = 1'b0;
      endcase
      return legal;
   endfunction

endpackage

// File: rtl/alu_share_arbiter_rr_arbiter.sv
// Round-robin picker: first asserted request at or after ptr, wrapping
// modulo N. Produces a one-hot grant, its index and an any-grant flag.
module rr_arbiter #(
   parameter int N     = 2,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic             enable,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   logic found_s;
   int   cand_s;

   // Scan from the pointer upward; the first hit wins.
   always_comb begin
      grant   = '0;
      idx     = '0;
      found_s = 1'b0;
      cand_s  = 0;
      for (int k = 0; k < N; k++) begin
         cand_s = int'(ptr) + k;
         if (cand_s >= N) begin
            cand_s = cand_s - N;
         end else begin
            cand_s = cand_s;
         end
         if (enable && !found_s && req[cand_s]) begin
            found_s       = 1'b1;
            grant[cand_s] = 1'b1;
            idx           = cand_s[IDX_W-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   assign any = found_s;

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between NUM_REQ requesters: round-robin grant,
// single-entry registered result slot returned to the owning requester.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = 32,
   parameter int OP_W    = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid_i,
   output logic [NUM_REQ-1:0]      req_ready_o,
   input  logic [NUM_REQ*DATA_W-1:0] req_opr_a_i,
   input  logic [NUM_REQ*DATA_W-1:0] req_opr_b_i,
   input  logic [NUM_REQ*OP_W-1:0] req_op_i,
   output logic [NUM_REQ-1:0]      rsp_valid_o,
   input  logic [NUM_REQ-1:0]      rsp_ready_i,
   output logic [DATA_W-1:0]       rsp_res_o,
   output logic                    rsp_z_o,
   output logic                    rsp_n_o,
   output logic                    rsp_err_o,
   output logic [DATA_W-1:0]       opr_a_alu_o,
   output logic [DATA_W-1:0]       opr_b_alu_o,
   output logic [OP_W-1:0]         op_alu_o,
   input  logic [DATA_W-1:0]       res_alu_i,
   input  logic                    z_alu_i,
   input  logic                    n_alu_i
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   slot_state_e         state_r;
   logic [IDX_W-1:0]    ptr_r;
   logic [IDX_W-1:0]    owner_r;
   logic [NUM_REQ-1:0]  rsp_valid_r;
   logic [DATA_W-1:0]   res_r;
   logic                z_r;
   logic                n_r;
   logic                err_r;

   logic                can_accept_s;
   logic [NUM_REQ-1:0]  grant_s;
   logic [IDX_W-1:0]    grant_idx_s;
   logic                grant_any_s;
   logic                op_legal_s;
   logic [IDX_W-1:0]    ptr_next_s;

   // A full slot only makes room when its owner takes the result this cycle.
   assign can_accept_s = (state_r == SLOT_EMPTY) || rsp_ready_i[owner_r];

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (IDX_W)
   ) u_rr (
      .req    (req_valid_i),
      .enable (can_accept_s && rst_n),
      .ptr    (ptr_r),
      .grant  (grant_s),
      .idx    (grant_idx_s),
      .any    (grant_any_s)
   );

   assign req_ready_o = grant_s;
   assign op_legal_s  = is_legal_alu_op(op_alu_o);
   assign ptr_next_s  = (grant_idx_s == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx_s + IDX_W'(1);

   // ALU operand mux; idle cycles present a benign ADD of zeros.
   always_comb begin
      opr_a_alu_o = '0;
      opr_b_alu_o = '0;
      op_alu_o    = ADD_OP;
      if (grant_any_s) begin
         opr_a_alu_o = req_opr_a_i[grant_idx_s*DATA_W +: DATA_W];
         opr_b_alu_o = req_opr_b_i[grant_idx_s*DATA_W +: DATA_W];
         op_alu_o    = req_op_i[grant_idx_s*OP_W +: OP_W];
      end else begin
         op_alu_o    = ADD_OP;
      end
   end

   // Slot FSM, round-robin pointer and registered response outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= SLOT_EMPTY;
         ptr_r       <= '0;
         owner_r     <= '0;
         rsp_valid_r <= '0;
         res_r       <= '0;
         z_r         <= 1'b0;
         n_r         <= 1'b0;
         err_r       <= 1'b0;
      end else if (grant_any_s) begin
         state_r     <= SLOT_FULL;
         owner_r     <= grant_idx_s;
         ptr_r       <= ptr_next_s;
         rsp_valid_r <= grant_s;
         if (op_legal_s) begin
            res_r <= res_alu_i;
            z_r   <= z_alu_i;
            n_r   <= n_alu_i;
            err_r <= 1'b0;
         end else begin
            res_r <= '0;
            z_r   <= 1'b0;
            n_r   <= 1'b0;
            err_r <= 1'b1;
         end
      end else begin
         case (state_r)
            SLOT_FULL: begin
               if (rsp_ready_i[owner_r]) begin
                  state_r     <= SLOT_EMPTY;
                  rsp_valid_r <= '0;
               end else begin
                  state_r     <= SLOT_FULL;
               end
            end
            SLOT_EMPTY: state_r <= SLOT_EMPTY;
            default: begin
               state_r     <= SLOT_EMPTY;
               rsp_valid_r <= '0;
            end
         endcase
      end
   end

   assign rsp_valid_o = rsp_valid_r;
   assign rsp_res_o   = res_r;
   assign rsp_z_o     = z_r;
   assign rsp_n_o     = n_r;
   assign rsp_err_o   = err_r;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: behavioural ALU environment, abstract slot model
// compared every cycle, directed scenarios pinned with literal values.
module tb_alu_share_arbiter;
   import alu_pkg::*;

   localparam int NR = 2;
   localparam int DW = 32;
   localparam int OW = 6;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NR-1:0]   req_valid;
   logic [NR-1:0]   req_ready;
   logic [NR*DW-1:0] req_a;
   logic [NR*DW-1:0] req_b;
   logic [NR*OW-1:0] req_op;
   logic [NR-1:0]   rsp_valid;
   logic [NR-1:0]   rsp_ready;
   logic [DW-1:0]   rsp_res;
   logic            rsp_z, rsp_n, rsp_err;
   logic [DW-1:0]   alu_a, alu_b, alu_res;
   logic [OW-1:0]   alu_op;
   logic            alu_z, alu_n;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .OP_W(OW)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_opr_a_i(req_a), .req_opr_b_i(req_b), .req_op_i(req_op),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_res_o(rsp_res), .rsp_z_o(rsp_z), .rsp_n_o(rsp_n), .rsp_err_o(rsp_err),
      .opr_a_alu_o(alu_a), .opr_b_alu_o(alu_b), .op_alu_o(alu_op),
      .res_alu_i(alu_res), .z_alu_i(alu_z), .n_alu_i(alu_n)
   );

   // {illegal, n, z, res} for a MIPS-style ALU
   function automatic logic [34:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                           input logic [5:0] op);
      logic [31:0] r;
      logic ill;
      ill = 1'b0;
      case (op)
         ADD_OP:  r = a + b;
         SUB_OP:  r = a - b;
         SHL_OP:  r = a << b[4:0];
         LSR_OP:  r = a >> b[4:0];
         ASR_OP:  r = $unsigned($signed(a) >>> b[4:0]);
         OR_OP:   r = a | b;
         AND_OP:  r = a & b;
         NOR_OP:  r = ~(a | b);
         XOR_OP:  r = a ^ b;
         SLT_OP:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         SLTU_OP: r = (a < b) ? 32'd1 : 32'd0;
         default: begin r = 32'd0; ill = 1'b1; end
      endcase
      return {ill, r[31], (r == 32'd0), r};
   endfunction

   // External ALU; garbage on undefined opcodes so forcing to zero is visible.
   always_comb begin
      logic [34:0] o;
      o = alu_ref(alu_a, alu_b, alu_op);
      if (o[34]) begin
         alu_res = 32'hDEAD_BEEF;
         alu_z   = 1'b1;
         alu_n   = 1'b1;
      end else begin
         alu_res = o[31:0];
         alu_z   = o[32];
         alu_n   = o[33];
      end
   end

   // ---------------- reference model ----------------
   logic        m_full;
   int          m_owner, m_ptr;
   logic [31:0] m_res;
   logic        m_z, m_n, m_err;

   function automatic int exp_grant();
      if (!rst_n) return -1;
      if (m_full && !rsp_ready[m_owner]) return -1;
      for (int k = 0; k < NR; k++) begin
         int j;
         j = (m_ptr + k) % NR;
         if (req_valid[j]) return j;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      int g;
      logic [34:0] o;
      if (!rst_n) begin
         m_full <= 1'b0; m_owner <= 0; m_ptr <= 0;
         m_res <= 32'd0; m_z <= 1'b0; m_n <= 1'b0; m_err <= 1'b0;
      end else begin
         g = exp_grant();
         if (g >= 0) begin
            o = alu_ref(req_a[g*DW +: DW], req_b[g*DW +: DW], req_op[g*OW +: OW]);
            m_full  <= 1'b1;
            m_owner <= g;
            m_ptr   <= (g + 1) % NR;
            m_res   <= o[34] ? 32'd0 : o[31:0];
            m_z     <= o[34] ? 1'b0 : o[32];
            m_n     <= o[34] ? 1'b0 : o[33];
            m_err   <= o[34];
         end else if (m_full && rsp_ready[m_owner]) begin
            m_full <= 1'b0;
         end
      end
   end

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      int g;
      logic [NR-1:0] e_rdy, e_vld;
      g = exp_grant();
      e_rdy = '0;
      e_vld = '0;
      if (g >= 0) e_rdy[g] = 1'b1;
      if (m_full) e_vld[m_owner] = 1'b1;
      chk("m_req_ready", req_ready, e_rdy);
      chk("m_rsp_valid", rsp_valid, e_vld);
      chk("m_rsp_res",   rsp_res, m_res);
      chk("m_rsp_flags", {rsp_err, rsp_n, rsp_z}, {m_err, m_n, m_z});
      chk("m_alu_a",  alu_a,  (g >= 0) ? req_a[g*DW +: DW] : 32'd0);
      chk("m_alu_b",  alu_b,  (g >= 0) ? req_b[g*DW +: DW] : 32'd0);
      chk("m_alu_op", alu_op, (g >= 0) ? req_op[g*OW +: OW] : ADD_OP);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] b);
      req_op[k*OW +: OW] = op;
      req_a[k*DW +: DW]  = a;
      req_b[k*DW +: DW]  = b;
   endtask

   logic [1:0] exp_seq [4];

   initial begin
      rst_n = 1'b0;
      req_valid = 2'b11;
      rsp_ready = 2'b00;
      req_a = '0; req_b = '0; req_op = '0;
      step(); step();
      chk("reset_ready", req_ready, 2'b00);
      chk("reset_valid", rsp_valid, 2'b00);
      chk("reset_res",   rsp_res, 32'd0);

      // first transaction after reset: ADD 3+4
      rst_n = 1'b1;
      req_valid = 2'b01;
      set_req(0, ADD_OP, 32'd3, 32'd4);
      #1;
      chk("first_ready", req_ready, 2'b01);
      chk("first_alu_a", alu_a, 32'd3);
      step();
      chk("first_valid", rsp_valid, 2'b01);
      chk("first_res",   rsp_res, 32'd7);
      chk("first_z",     rsp_z, 1'b0);
      req_valid = 2'b00;
      rsp_ready = 2'b01;
      step();
      chk("drain_valid", rsp_valid, 2'b00);
      chk("drain_hold",  rsp_res, 32'd7);

      // contention, pointer now at 1
      req_valid = 2'b11;
      rsp_ready = 2'b11;
      set_req(0, ADD_OP, 32'd1, 32'd1);
      set_req(1, ADD_OP, 32'd10, 32'd20);
      exp_seq[0] = 2'b10; exp_seq[1] = 2'b01; exp_seq[2] = 2'b10; exp_seq[3] = 2'b01;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("rr_ready", req_ready, exp_seq[i]);
         step();
         chk("rr_valid", rsp_valid, exp_seq[i]);
         chk("rr_res", rsp_res, (exp_seq[i] == 2'b10) ? 32'd30 : 32'd2);
      end
      req_valid = 2'b00;
      step();

      // backpressure: SUB 5-5 for requester 1 held three cycles
      req_valid = 2'b10;
      rsp_ready = 2'b00;
      set_req(1, SUB_OP, 32'd5, 32'd5);
      step();
      req_valid = 2'b11;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_ready", req_ready, 2'b00);
         step();
         chk("bp_valid", rsp_valid, 2'b10);
         chk("bp_res_z", {rsp_z, rsp_res}, {1'b1, 32'd0});
      end
      rsp_ready = 2'b10;
      #1;
      chk("bp_resume", req_ready, 2'b01);
      step();
      chk("bp_next", rsp_valid, 2'b01);

      // drain and refill in the same cycle
      req_valid = 2'b10;
      rsp_ready = 2'b01;
      set_req(1, ADD_OP, 32'd7, 32'd8);
      #1;
      chk("da_ready", req_ready, 2'b10);
      step();
      chk("da_valid", rsp_valid, 2'b10);
      chk("da_res",   rsp_res, 32'd15);

      // illegal opcode then SLT(-1,1)
      req_valid = 2'b01;
      rsp_ready = 2'b10;
      set_req(0, 6'h3F, 32'd9, 32'd9);
      step();
      chk("ill_err", {rsp_err, rsp_n, rsp_z}, 3'b100);
      chk("ill_res", rsp_res, 32'd0);
      rsp_ready = 2'b01;
      set_req(0, SLT_OP, 32'hFFFF_FFFF, 32'd1);
      step();
      chk("slt_res", rsp_res, 32'd1);
      chk("slt_err", rsp_err, 1'b0);

      // idle: benign ALU drive, pointer (at 1) unchanged
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      #1;
      chk("idle_op", alu_op, ADD_OP);
      chk("idle_opr", {alu_a, alu_b}, 64'd0);
      step(); step();
      req_valid = 2'b11;
      #1;
      chk("idle_ptr", req_ready, 2'b10);
      step();
      req_valid = 2'b00;
      rsp_ready = 2'b00;
      step();

      // reset while the slot is full
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", rsp_valid, 2'b00);
      req_valid = 2'b11;
      #1;
      chk("mid_rst_ready", req_ready, 2'b00);
      step();
      rst_n = 1'b1;
      #1;
      chk("post_rst_ready", req_ready, 2'b01);
      step();
      chk("post_rst_res", rsp_res, 32'd1);

      // randomized traffic, checked by the model every cycle
      for (int c = 0; c < 3000; c++) begin
         step();
         req_valid = NR'($urandom);
         rsp_ready = {($urandom_range(0, 2) != 0), ($urandom_range(0, 2) != 0)};
         for (int k = 0; k < NR; k++) begin
            int s;
            s = $urandom_range(0, 11);
            set_req(k, (s == 11) ? 6'($urandom) : 6'(s),
                    ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom,
                    ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom);
         end
         rst_n = ($urandom_range(0, 299) != 0);
      end
      rst_n = 1'b1;
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
